coef_packer: RTL and testbench

// - Stage directly downstream of the attention-coefficient (DMVM) stage; drains its coef FIFO (one

---
 rtl/coef_packer_if.sv | 30 +++
 rtl/coef_packer.sv | 129 ++++++++++++
 tb/tb_coef_packer.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/coef_packer_if.sv
// FIFO-side bundle of the coefficient packer: coef/node-count read ports and softmax write port.
// The packer connects as master; the FIFO/testbench side connects as slave.
interface coef_packer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_NODES  = 168
);
    localparam int NUM_NODE_WIDTH = $clog2(MAX_NODES);
    localparam int SOFTMAX_WIDTH  = MAX_NODES * DATA_WIDTH + NUM_NODE_WIDTH;

    logic [DATA_WIDTH-1:0]     coef_ff_dout;
    logic                      coef_ff_empty;
    logic                      coef_ff_rd_vld;
    logic [NUM_NODE_WIDTH-1:0] nn_ff_dout;
    logic                      nn_ff_empty;
    logic                      nn_ff_rd_vld;
    logic [SOFTMAX_WIDTH-1:0]  sm_ff_din;
    logic                      sm_ff_full;
    logic                      sm_ff_wr_vld;
    logic [DATA_WIDTH-1:0]     coef_max_o;

    modport master (
        input  coef_ff_dout, coef_ff_empty, nn_ff_dout, nn_ff_empty, sm_ff_full,
        output coef_ff_rd_vld, nn_ff_rd_vld, sm_ff_din, sm_ff_wr_vld, coef_max_o
    );

    modport slave (
        output coef_ff_dout, coef_ff_empty, nn_ff_dout, nn_ff_empty, sm_ff_full,
        input  coef_ff_rd_vld, nn_ff_rd_vld, sm_ff_din, sm_ff_wr_vld, coef_max_o
    );
endinterface

// File: rtl/coef_packer.sv
// Regroups the per-edge coefficient stream into one packed softmax word per subgraph,
// carrying the clamped node count and the packet's maximum coefficient.
module coef_packer #(
    parameter int DATA_WIDTH    = 8,
    parameter int MAX_NODES     = 168,
    parameter int NUM_SUBGRAPHS = 2708
) (
    input  logic          clk,
    input  logic          rst_n,
    coef_packer_if.master bus,
    output logic          err_o,
    output logic          done_o
);
    localparam int NUM_NODE_WIDTH = $clog2(MAX_NODES);
    localparam int SOFTMAX_WIDTH  = MAX_NODES * DATA_WIDTH + NUM_NODE_WIDTH;
    localparam int SG_CNT_W       = $clog2(NUM_SUBGRAPHS + 1);

    localparam logic [NUM_NODE_WIDTH-1:0] MAX_N    = NUM_NODE_WIDTH'(MAX_NODES);
    localparam logic [SG_CNT_W-1:0]       SG_TOTAL = SG_CNT_W'(NUM_SUBGRAPHS);

    typedef enum logic [1:0] {IDLE, COLLECT, PUSH} state_t;

    state_t                    state_q, state_d;
    logic [DATA_WIDTH-1:0]     slot_q [MAX_NODES];
    logic [NUM_NODE_WIDTH-1:0] idx_q, idx_d;
    logic [NUM_NODE_WIDTH-1:0] n_q, n_d;
    logic [DATA_WIDTH-1:0]     max_q, max_d;
    logic [SG_CNT_W-1:0]       cnt_q, cnt_d;
    logic                      err_q, err_d;
    logic                      coef_pop, nn_pop, push;
    logic [SOFTMAX_WIDTH-1:0]  packed_w;

    function automatic logic [NUM_NODE_WIDTH-1:0] clamp_n(input logic [NUM_NODE_WIDTH-1:0] n);
        return (n > MAX_N) ? MAX_N : n;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] umax(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
        return (b > a) ? b : a;
    endfunction

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        n_d      = n_q;
        max_d    = max_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        coef_pop = 1'b0;
        nn_pop   = 1'b0;
        push     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!done_o && !bus.nn_ff_empty) begin
                    nn_pop = 1'b1;
                    n_d    = clamp_n(bus.nn_ff_dout);
                    idx_d  = '0;
                    if (bus.nn_ff_dout > MAX_N) err_d = 1'b1;
                    // An empty subgraph still produces exactly one (all-zero) packet.
                    state_d = (bus.nn_ff_dout == '0) ? PUSH : COLLECT;
                end
            end
            COLLECT: begin
                if (!bus.coef_ff_empty) begin
                    coef_pop = 1'b1;
                    idx_d    = idx_q + 1'b1;
                    max_d    = umax(max_q, bus.coef_ff_dout);
                    if (idx_q == n_q - 1'b1) state_d = PUSH;
                end
            end
            PUSH: begin
                if (!bus.sm_ff_full) begin
                    push    = 1'b1;
                    idx_d   = '0;
                    n_d     = '0;
                    max_d   = '0;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            n_q     <= '0;
            max_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            max_q   <= max_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Slots are wiped on every push so short packets never carry stale coefs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < MAX_NODES; k++) slot_q[k] <= '0;
        end else if (push) begin
            for (int k = 0; k < MAX_NODES; k++) slot_q[k] <= '0;
        end else if (coef_pop) begin
            slot_q[idx_q] <= bus.coef_ff_dout;
        end
    end

    always_comb begin
        packed_w = '0;
        for (int k = 0; k < MAX_NODES; k++) begin
            packed_w[SOFTMAX_WIDTH-1-k*DATA_WIDTH -: DATA_WIDTH] = slot_q[k];
        end
        packed_w[NUM_NODE_WIDTH-1:0] = n_q;
    end

    assign bus.coef_ff_rd_vld = coef_pop;
    assign bus.nn_ff_rd_vld   = nn_pop;
    assign bus.sm_ff_wr_vld   = push;
    assign bus.sm_ff_din      = packed_w;
    assign bus.coef_max_o     = max_q;
    assign err_o              = err_q;
    assign done_o             = (cnt_q == SG_TOTAL);
endmodule

// File: tb/tb_coef_packer.sv
// Bench for coef_packer: behavioural FWFT FIFOs around the DUT, a packet scoreboard,
// a table of single-packet scenarios and hand-written multi-packet/reset sequences.
module tb_coef_packer;
  localparam int DW  = 8;
  localparam int MN  = 168;
  localparam int NSG = 2;
  localparam int NNW = $clog2(MN);
  localparam int SW  = MN * DW + NNW;

  typedef logic [DW-1:0] bq_t[$];
  typedef struct {
    logic [SW-1:0] din;
    logic [DW-1:0] mx;
    int            lat;
  } exp_t;
  typedef struct {
    int n;
    int c0, c1, c2, c3;
    int seed;
    int gap;
    int full;
    int lat;
    bit err;
  } row_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err, done;

  coef_packer_if #(.DATA_WIDTH(DW), .MAX_NODES(MN)) ifc ();

  coef_packer #(.DATA_WIDTH(DW), .MAX_NODES(MN), .NUM_SUBGRAPHS(NSG)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (ifc),
    .err_o  (err),
    .done_o (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  bq_t coef_fifo;
  logic [NNW-1:0] nn_fifo[$];
  exp_t sb[$];
  int gap = 0, gap_cnt = 0, full_cnt = 0;
  int coef_pops = 0, nn_pops = 0, pushes = 0, nn_pop_cyc = 0;
  bit pend_c = 0, pend_n = 0;

  task automatic chk(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [DW-1:0] gen(input int seed, input int i);
    return DW'((seed * 37 + i * 101 + 17) % 256);
  endfunction

  // Shift-in construction: slot 0 lands in the top byte, node count in the low field.
  function automatic logic [SW-1:0] mk_pkt(input bq_t c, input int ne);
    logic [SW-1:0] p = '0;
    for (int k = 0; k < MN; k++) begin
      p = p << DW;
      if (k < ne) p[DW-1:0] = c[k];
    end
    p = p << NNW;
    p[NNW-1:0] = NNW'(ne);
    return p;
  endfunction

  function automatic logic [DW-1:0] mk_max(input bq_t c, input int ne);
    logic [DW-1:0] m = '0;
    for (int k = 0; k < ne; k++) if (c[k] > m) m = c[k];
    return m;
  endfunction

  task automatic expect_pkt(input bq_t c, input int ne, input int lat);
    exp_t e;
    e.din = mk_pkt(c, ne);
    e.mx  = mk_max(c, ne);
    e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic step();
    logic [DW-1:0] tc;
    logic [NNW-1:0] tn;
    exp_t e;
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      pend_c = 0;
      pend_n = 0;
    end
    if (pend_n && nn_fifo.size() > 0) begin
      tn = nn_fifo.pop_front();
      nn_pops++;
    end
    if (pend_c && coef_fifo.size() > 0) begin
      tc = coef_fifo.pop_front();
      coef_pops++;
      gap_cnt = gap;
    end else if (gap_cnt > 0) begin
      gap_cnt--;
    end
    ifc.coef_ff_empty = (coef_fifo.size() == 0) || (gap_cnt > 0);
    ifc.coef_ff_dout  = (coef_fifo.size() > 0 && gap_cnt == 0) ? coef_fifo[0] : 8'hEE;
    ifc.nn_ff_empty   = (nn_fifo.size() == 0);
    ifc.nn_ff_dout    = (nn_fifo.size() > 0) ? nn_fifo[0] : 8'hAA;
    ifc.sm_ff_full    = (full_cnt > 0);
    if (full_cnt > 0) full_cnt--;
    #1;
    pend_c = ifc.coef_ff_rd_vld;
    pend_n = ifc.nn_ff_rd_vld;
    if (pend_c) chk("coef_pop_nonempty", ifc.coef_ff_empty, 0);
    if (pend_n) begin
      chk("nn_pop_nonempty", ifc.nn_ff_empty, 0);
      nn_pop_cyc = cyc;
    end
    if (ifc.sm_ff_wr_vld) begin
      pushes++;
      chk("push_not_full", ifc.sm_ff_full, 0);
      if (sb.size() == 0) begin
        chk("unexpected_push", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("sm_ff_din", ifc.sm_ff_din, e.din);
        chk("coef_max", ifc.coef_max_o, e.mx);
        if (e.lat >= 0) chk("latency", cyc - nn_pop_cyc, e.lat);
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    coef_fifo.delete();
    nn_fifo.delete();
    sb.delete();
    gap = 0; gap_cnt = 0; full_cnt = 0;
    coef_pops = 0; nn_pops = 0; pushes = 0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic run_until_drained(input int limit);
    for (int k = 0; k < limit && sb.size() > 0; k++) step();
    chk("timeout_pending_packets", sb.size(), 0);
  endtask

  task automatic run_row(input int idx, input row_t r);
    bq_t cs;
    int ne, nc, v;
    logic [SW-1:0] exp_din, cap_din;
    logic [DW-1:0] exp_mx, cap_mx;
    do_reset();
    ne = (r.n > MN) ? MN : r.n;
    nc = (r.n > MN) ? ne + 2 : ne;
    for (int i = 0; i < nc; i++) begin
      case (i)
        0: v = r.c0;
        1: v = r.c1;
        2: v = r.c2;
        3: v = r.c3;
        default: v = -1;
      endcase
      cs.push_back((v >= 0) ? DW'(v) : gen(r.seed, i));
    end
    exp_din = mk_pkt(cs, ne);
    exp_mx  = mk_max(cs, ne);
    cap_din = '0;
    cap_mx  = '0;
    coef_fifo = cs;
    nn_fifo.push_back(NNW'(r.n));
    gap = r.gap;
    full_cnt = r.full;
    expect_pkt(cs, ne, r.lat);
    for (int k = 0; k < 600 && sb.size() > 0; k++) begin
      step();
      if (r.full > 0 && k == r.full - 2) begin
        cap_din = ifc.sm_ff_din;
        cap_mx  = ifc.coef_max_o;
        chk($sformatf("row%0d_no_push_while_full", idx), ifc.sm_ff_wr_vld, 0);
      end
    end
    chk($sformatf("row%0d_timeout", idx), sb.size(), 0);
    step();
    step();
    chk($sformatf("row%0d_err", idx), err, r.err);
    chk($sformatf("row%0d_coef_pops", idx), coef_pops, ne);
    chk($sformatf("row%0d_nn_pops", idx), nn_pops, 1);
    chk($sformatf("row%0d_pushes", idx), pushes, 1);
    chk($sformatf("row%0d_done", idx), done, 0);
    if (r.full > 0) begin
      chk($sformatf("row%0d_din_held", idx), cap_din, exp_din);
      chk($sformatf("row%0d_max_held", idx), cap_mx, exp_mx);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    row_t rows[7];
    bq_t cs;
    ifc.coef_ff_empty = 1'b1;
    ifc.coef_ff_dout  = '0;
    ifc.nn_ff_empty   = 1'b1;
    ifc.nn_ff_dout    = '0;
    ifc.sm_ff_full    = 1'b0;

    //        n    c0   c1   c2   c3  seed gap full lat  err
    rows[0] = '{3,   5,   9,   2,  -1,   0,  0,   0,   4, 1'b0};
    rows[1] = '{4,  11,   3, 200,   4,   0,  2,   0,  -1, 1'b0};
    rows[2] = '{2,   6,   1,  -1,  -1,   0,  0,  12,  -1, 1'b0};
    rows[3] = '{0,  -1,  -1,  -1,  -1,   0,  0,   0,   1, 1'b0};
    rows[4] = '{200, -1, -1,  -1,  -1,   1,  0,   0, 169, 1'b1};
    rows[5] = '{5,  -1,  -1,  -1,  -1,   2,  0,   0,   6, 1'b0};
    rows[6] = '{168, -1, -1,  -1,  -1,   3,  0,   0, 169, 1'b0};

    rst_n = 1'b0;
    step();
    step();
    chk("rst_coef_rd", ifc.coef_ff_rd_vld, 0);
    chk("rst_nn_rd", ifc.nn_ff_rd_vld, 0);
    chk("rst_wr", ifc.sm_ff_wr_vld, 0);
    chk("rst_din", ifc.sm_ff_din, 0);
    chk("rst_max", ifc.coef_max_o, 0);
    chk("rst_err", err, 0);
    chk("rst_done", done, 0);

    for (int i = 0; i < 7; i++) run_row(i, rows[i]);

    // Packet of 3 then packet of 1; second reaches the layer total so the third n stays queued.
    do_reset();
    cs = '{8'd5, 8'd9, 8'd2, 8'd7, 8'd44, 8'd55};
    coef_fifo = cs;
    nn_fifo = '{NNW'(3), NNW'(1), NNW'(2)};
    expect_pkt('{8'd5, 8'd9, 8'd2}, 3, 4);
    expect_pkt('{8'd7}, 1, 2);
    run_until_drained(100);
    for (int k = 0; k < 10; k++) step();
    chk("seqA_done", done, 1);
    chk("seqA_nn_left", nn_fifo.size(), 1);
    chk("seqA_coef_pops", coef_pops, 4);
    chk("seqA_pushes", pushes, 2);

    // Oversized count followed by an empty packet: err stays set until reset.
    do_reset();
    cs.delete();
    for (int i = 0; i < MN; i++) cs.push_back(gen(4, i));
    coef_fifo = cs;
    nn_fifo = '{NNW'(200), NNW'(0)};
    expect_pkt(cs, MN, 169);
    cs.delete();
    expect_pkt(cs, 0, 1);
    run_until_drained(400);
    step();
    step();
    chk("seqB_err_sticky", err, 1);
    chk("seqB_done", done, 1);
    do_reset();
    chk("seqB_err_cleared", err, 0);
    chk("seqB_done_cleared", done, 0);

    // One full packet, then reset while the second is mid-collect.
    do_reset();
    coef_fifo = '{8'd33, 8'd1, 8'd2};
    nn_fifo = '{NNW'(1), NNW'(4)};
    expect_pkt('{8'd33}, 1, 2);
    run_until_drained(100);
    for (int k = 0; k < 8; k++) step();
    chk("seqC_pushes_before_rst", pushes, 1);
    chk("seqC_coef_pops", coef_pops, 3);
    rst_n = 1'b0;
    step();
    chk("seqC_rst_din", ifc.sm_ff_din, 0);
    chk("seqC_rst_max", ifc.coef_max_o, 0);
    chk("seqC_rst_wr", ifc.sm_ff_wr_vld, 0);
    do_reset();
    coef_fifo = '{8'd77};
    nn_fifo = '{NNW'(1)};
    expect_pkt('{8'd77}, 1, 2);
    run_until_drained(100);
    step();
    step();
    chk("seqC_done_after_rst", done, 0);
    chk("seqC_pushes_after_rst", pushes, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
